// File: rtl/hdmux_router.sv
// Registered 1-to-CHANNELS demultiplexer with valid/ready handshaking.
// Each channel has a one-entry holding register; words go to one channel or are broadcast to all.
module hdmux_router #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_bcast,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [7:0]                drop_count
);

   localparam int unsigned DW = CHANNELS * WIDTH;

   logic [CHANNELS-1:0] r_valid;
   logic [DW-1:0]       r_data;
   logic [7:0]          r_drop;

   logic [CHANNELS-1:0] w_free;
   logic [CHANNELS-1:0] w_hit;
   logic [CHANNELS-1:0] w_load;
   logic                w_in_range;
   logic                w_accept;
   logic                w_drop;

   // A channel can take a word when empty or when its consumer drains it this cycle.
   assign w_free = ~r_valid | out_ready;

   // Unicast destination decode; an out-of-range select matches no channel.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         w_hit[i] = (in_sel == SEL_W'(i));
      end
   end

   assign w_in_range = |w_hit;

   always_comb begin
      in_ready = 1'b1;
      if (in_bcast) begin
         in_ready = &w_free;
      end else if (w_in_range) begin
         in_ready = |(w_hit & w_free);
      end
   end

   assign w_accept = in_valid & in_ready;
   assign w_load   = {CHANNELS{w_accept}} & (in_bcast ? {CHANNELS{1'b1}} : w_hit);
   assign w_drop   = w_accept & ~in_bcast & ~w_in_range;

   // Holding registers: reload wins over drain; data is retained after drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid <= (r_valid & ~out_ready) | w_load;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (w_load[i]) begin
               r_data[i*WIDTH +: WIDTH] <= in_data;
            end
         end
      end
   end

   // Saturating count of words discarded for an out-of-range select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop <= '0;
      end else if (w_drop && (r_drop != 8'hFF)) begin
         r_drop <= r_drop + 8'd1;
      end
   end

   assign out_valid  = r_valid;
   assign out_data   = r_data;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_hdmux_router.sv
// Bench for hdmux_router: directed and random traffic against an array-based model of the
// channel holding registers; a second 5-channel instance exercises the drop counter.
module tb_hdmux_router;

   localparam int unsigned W   = 16;
   localparam int unsigned CH  = 8;
   localparam int unsigned SW  = 3;
   localparam int unsigned CH5 = 5;
   localparam int unsigned SW5 = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             in_valid, in_ready, in_bcast;
   logic [W-1:0]     in_data;
   logic [SW-1:0]    in_sel;
   logic [CH-1:0]    out_valid, out_ready;
   logic [CH*W-1:0]  out_data;
   logic [7:0]       drop_count;

   logic             b_in_valid, b_in_ready, b_in_bcast;
   logic [W-1:0]     b_in_data;
   logic [SW5-1:0]   b_in_sel;
   logic [CH5-1:0]   b_out_valid, b_out_ready;
   logic [CH5*W-1:0] b_out_data;
   logic [7:0]       b_drop_count;

   hdmux_router #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .drop_count(drop_count)
   );

   hdmux_router #(.WIDTH(W), .CHANNELS(CH5)) dut5 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_sel(b_in_sel), .in_bcast(b_in_bcast),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .drop_count(b_drop_count)
   );

   int errors = 0;
   int checks = 0;
   logic         mv [CH];
   logic [W-1:0] md [CH];
   logic         last_rdy;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Acceptance rule straight from the channel occupancy model.
   function automatic logic model_ready();
      logic r;
      if (in_bcast) begin
         r = 1'b1;
         for (int i = 0; i < int'(CH); i++) r = r && (!mv[i] || out_ready[i]);
      end else if (int'(in_sel) < int'(CH)) begin
         r = !mv[in_sel] || out_ready[in_sel];
      end else begin
         r = 1'b1;
      end
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < int'(CH); i++) begin
         mv[i] = 1'b0;
         md[i] = '0;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [CH-1:0]   ev;
      logic [CH*W-1:0] ed;
      for (int i = 0; i < int'(CH); i++) begin
         ev[i]         = mv[i];
         ed[i*W +: W]  = md[i];
      end
      chk({tag, ".out_valid"}, 128'(out_valid), 128'(ev));
      chk({tag, ".out_data"}, 128'(out_data), 128'(ed));
   endtask

   // Called just after a falling edge with inputs driven: check in_ready, clock once, check outputs.
   task automatic cycle(input string tag);
      logic r, acc;
      #1;
      r = model_ready();
      chk({tag, ".in_ready"}, 128'(in_ready), 128'(r));
      last_rdy = r;
      acc = in_valid && r;
      @(posedge clk);
      for (int i = 0; i < int'(CH); i++) begin
         if (acc && (in_bcast || int'(in_sel) == i)) begin
            mv[i] = 1'b1;
            md[i] = in_data;
         end else if (mv[i] && out_ready[i]) begin
            mv[i] = 1'b0;
         end
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic drive(input logic v, input int sel, input logic bc, input logic [W-1:0] d,
                        input logic [CH-1:0] ordy);
      in_valid  = v;
      in_sel    = SW'(sel);
      in_bcast  = bc;
      in_data   = d;
      out_ready = ordy;
   endtask

   initial begin
      logic hold;
      logic [CH*W-1:0] exp_d;
      rst_n = 1'b0;
      drive(1'b0, 0, 1'b0, '0, '0);
      b_in_valid = 1'b0; b_in_sel = '0; b_in_bcast = 1'b0; b_in_data = '0; b_out_ready = '0;
      model_clear();
      last_rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset");
      chk("reset.drop_count", 128'(drop_count), 128'(0));
      chk("reset.b_drop_count", 128'(b_drop_count), 128'(0));
      rst_n = 1'b1;

      // Fill every channel with 0x00A0+sel, consumers stalled.
      for (int s = 0; s < 8; s++) begin
         drive(1'b1, s, 1'b0, W'(16'h00A0 + s), '0);
         cycle("fill");
      end
      for (int s = 0; s < 8; s++) exp_d[s*W +: W] = W'(16'h00A0 + s);
      chk("fill.all_valid", 128'(out_valid), 128'(8'hFF));
      chk("fill.all_data", 128'(out_data), 128'(exp_d));

      // Channel 3 stalled: word held; channel 5 can proceed independently.
      drive(1'b1, 3, 1'b0, 16'h1234, '0);
      cycle("stall3");
      cycle("stall3b");
      drive(1'b1, 5, 1'b0, 16'h5555, 8'h20);
      cycle("ch5_free");
      drive(1'b1, 3, 1'b0, 16'h1234, 8'h08);
      cycle("ch3_release");
      chk("ch3_data", 128'(out_data[3*W +: W]), 128'(16'h1234));
      chk("ch3_valid", 128'(out_valid[3]), 128'(1'b1));

      // Channel 2 streaming with a continuously ready consumer.
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 2, 1'b0, W'(k), 8'h04);
         cycle("stream");
         chk("stream.word", 128'(out_data[2*W +: W]), 128'(k));
      end
      drive(1'b0, 0, 1'b0, '0, 8'hBF);
      cycle("drain_all_but_6");

      // Broadcast blocked by stalled channel 6, then released.
      drive(1'b1, 0, 1'b1, 16'hBEEF, 8'h00);
      cycle("bcast_blocked");
      cycle("bcast_blocked2");
      drive(1'b1, 0, 1'b1, 16'hBEEF, 8'h40);
      cycle("bcast_go");
      for (int s = 0; s < 8; s++) exp_d[s*W +: W] = 16'hBEEF;
      chk("bcast.all_data", 128'(out_data), 128'(exp_d));
      chk("bcast.all_valid", 128'(out_valid), 128'(8'hFF));

      // Random traffic; inputs are held while a word waits for acceptance.
      hold = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (!hold) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
                  W'($urandom), CH'($urandom));
         end else begin
            out_ready = CH'($urandom);
         end
         cycle("rand");
         hold = in_valid && !last_rdy;
      end
      drive(1'b0, 0, 1'b0, '0, '0);

      // 5-channel instance: out-of-range selects are dropped and counted up to 255.
      for (int n = 1; n <= 300; n++) begin
         b_in_valid = 1'b1; b_in_sel = SW5'(6); b_in_data = W'(n);
         #1;
         if (n % 50 == 1) chk("drop.in_ready", 128'(b_in_ready), 128'(1'b1));
         @(negedge clk);
         if (n % 50 == 0 || n == 255 || n == 256) begin
            chk("drop.count", 128'(b_drop_count), 128'((n > 255) ? 255 : n));
            chk("drop.out_valid", 128'(b_out_valid), 128'(0));
         end
      end
      b_in_valid = 1'b0;

      // Fill all channels, then assert reset asynchronously between edges.
      drive(1'b1, 0, 1'b1, 16'hC0DE, '0);
      cycle("prefill");
      drive(1'b0, 0, 1'b1, 16'h0000, '0);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_outputs("async_rst");
      chk("async_rst.in_ready", 128'(in_ready), 128'(1'b1));
      chk("async_rst.b_drop", 128'(b_drop_count), 128'(0));
      chk("async_rst.b_valid", 128'(b_out_valid), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 4, 1'b0, 16'h4444, '0);
      cycle("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
